// File: rtl/aes_key_expand.sv
// aes_key_expand: sequential AES-128 key schedule, one 32-bit round-key word per rk handshake.
// Define AES_KEYEXP_REVERSE_EN to buffer the whole schedule and stream it in inverse-cipher round order.
module aes_key_expand #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_valid,
    output logic                  key_ready,
    input  logic [127:0]          key_in,
    output logic                  rk_valid,
    input  logic                  rk_ready,
    output logic [DATA_WIDTH-1:0] rk_data,
    output logic [3:0]            rk_round,
    output logic                  rk_last,
    output logic                  busy
);
    // state  | meaning
    // IDLE   | waiting for a key, key_ready high
    // GEN    | reverse build only: filling the buffer with w4..w43, no output yet
    // STREAM | presenting rk_data until the last word handshakes
`ifdef AES_KEYEXP_REVERSE_EN
    typedef enum logic [1:0] {IDLE, GEN, STREAM} state_t;
`else
    typedef enum logic {IDLE, STREAM} state_t;
`endif

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t                state;
    logic [5:0]            cnt;
    logic [5:0]            gen_n;
    logic [DATA_WIDTH-1:0] win [4];
    logic [DATA_WIDTH-1:0] rot;
    logic [DATA_WIDTH-1:0] temp;
    logic [DATA_WIDTH-1:0] new_word;

    // win holds w[gen_n-4 .. gen_n-1]; gen_n is the index of the word being generated
`ifdef AES_KEYEXP_REVERSE_EN
    assign gen_n = cnt;
`else
    assign gen_n = cnt + 6'd1;
`endif

    always_comb begin
        rot  = {win[3][23:0], win[3][31:24]};
        temp = win[3];
        if (gen_n[1:0] == 2'd0)
            temp = {sbox(rot[31:24]) ^ rcon(gen_n[5:2]), sbox(rot[23:16]),
                    sbox(rot[15:8]), sbox(rot[7:0])};
        new_word = win[0] ^ temp;
    end

    assign key_ready = (state == IDLE);
    assign rk_round  = cnt[5:2];

`ifdef AES_KEYEXP_REVERSE_EN
    logic [DATA_WIDTH-1:0] kbuf [44];
    logic [5:0]            rev_next;
    logic                  gen_done;

    // within a round words ascend, then drop to the first word of the previous round
    assign rev_next = (cnt[1:0] == 2'd3) ? cnt - 6'd7 : cnt + 6'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == IDLE && key_valid) begin
                kbuf[0] <= key_in[127:96];
                kbuf[1] <= key_in[95:64];
                kbuf[2] <= key_in[63:32];
                kbuf[3] <= key_in[31:0];
            end else if (state == GEN && !gen_done) begin
                kbuf[cnt] <= new_word;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rk_valid <= 1'b0;
            rk_data  <= '0;
            rk_last  <= 1'b0;
            busy     <= 1'b0;
            for (int k = 0; k < 4; k++) win[k] <= '0;
`ifdef AES_KEYEXP_REVERSE_EN
            gen_done <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (key_valid) begin
                        win[0]  <= key_in[127:96];
                        win[1]  <= key_in[95:64];
                        win[2]  <= key_in[63:32];
                        win[3]  <= key_in[31:0];
                        busy    <= 1'b1;
                        rk_last <= 1'b0;
`ifdef AES_KEYEXP_REVERSE_EN
                        cnt      <= 6'd4;
                        gen_done <= 1'b0;
                        state    <= GEN;
`else
                        cnt      <= '0;
                        rk_data  <= key_in[127:96];
                        rk_valid <= 1'b1;
                        state    <= STREAM;
`endif
                    end
                end
`ifdef AES_KEYEXP_REVERSE_EN
                GEN: begin
                    if (gen_done) begin
                        state    <= STREAM;
                        rk_valid <= 1'b1;
                        rk_data  <= kbuf[40];
                        cnt      <= 6'd40;
                    end else begin
                        win[0] <= win[1];
                        win[1] <= win[2];
                        win[2] <= win[3];
                        win[3] <= new_word;
                        if (cnt == 6'd43)
                            gen_done <= 1'b1;
                        else
                            cnt <= cnt + 6'd1;
                    end
                end
`endif
                STREAM: begin
                    if (rk_ready) begin
                        if (rk_last) begin
                            state    <= IDLE;
                            rk_valid <= 1'b0;
                            rk_last  <= 1'b0;
                            busy     <= 1'b0;
                        end else begin
`ifdef AES_KEYEXP_REVERSE_EN
                            rk_data <= kbuf[rev_next];
                            cnt     <= rev_next;
                            rk_last <= (rev_next == 6'd3);
`else
                            cnt     <= cnt + 6'd1;
                            rk_last <= (cnt == 6'd42);
                            if (cnt < 6'd3) begin
                                rk_data <= win[cnt[1:0] + 2'd1];
                            end else begin
                                rk_data <= new_word;
                                win[0]  <= win[1];
                                win[1]  <= win[2];
                                win[2]  <= win[3];
                                win[3]  <= new_word;
                            end
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: a GF(2^8)-derived key-schedule model feeds an expected-word
// queue that a negedge monitor compares against every presented word; directed literals pin the model.
module tb_aes_key_expand;
`ifdef AES_KEYEXP_REVERSE_EN
    localparam bit REV     = 1'b1;
    localparam int EXP_LAT = 41;
`else
    localparam bit REV     = 1'b0;
    localparam int EXP_LAT = 1;
`endif
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key_in;
    logic         rk_valid;
    logic         rk_ready;
    logic [31:0]  rk_data;
    logic [3:0]   rk_round;
    logic         rk_last;
    logic         busy;

    aes_key_expand #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data), .rk_round(rk_round),
        .rk_last(rk_last), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  round;
        logic        last;
    } rk_t;

    rk_t         exp_q [$];
    rk_t         head;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  sbox_m  [256];
    logic [31:0] model_w [44];
    logic [31:0] got_data  [44];
    logic [3:0]  got_round [44];
    logic        got_last  [44];
    int          got_n = 0;
    int          lat = 0;
    bit          waiting = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] t = {v, v};
        t = t << n;
        return t[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map
    function automatic void build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endfunction

    function automatic void expand(input logic [127:0] key);
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) model_w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = model_w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            model_w[i] = model_w[i-4] ^ t;
        end
    endfunction

    function automatic void push_expected(input logic [127:0] key);
        int  idx;
        rk_t e;
        expand(key);
        for (int p = 0; p < 44; p++) begin
            idx     = REV ? 4 * (10 - p / 4) + p % 4 : p;
            e.data  = model_w[idx];
            e.round = 4'(idx / 4);
            e.last  = (p == 43);
            exp_q.push_back(e);
        end
    endfunction

    always @(negedge clk) begin
        lat++;
        if (rst) begin
            prev_stall = 1'b0;
            waiting    = 1'b0;
        end else begin
            check("busy", {31'b0, busy}, {31'b0, exp_q.size() != 0});
            check("key_ready", {31'b0, key_ready}, {31'b0, exp_q.size() == 0});
            if (prev_stall) begin
                check("valid_held", {31'b0, rk_valid}, 32'd1);
                check("data_held", rk_data, prev_data);
            end
            if (rk_valid) begin
                if (waiting) begin
                    check("first_valid_latency", lat, EXP_LAT);
                    waiting = 1'b0;
                end
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_word");
                end else begin
                    head = exp_q[0];
                    check("rk_data", rk_data, head.data);
                    check("rk_round", {28'b0, rk_round}, {28'b0, head.round});
                    check("rk_last", {31'b0, rk_last}, {31'b0, head.last});
                    if (rk_ready) begin
                        if (got_n < 44) begin
                            got_data[got_n]  = rk_data;
                            got_round[got_n] = rk_round;
                            got_last[got_n]  = rk_last;
                        end
                        got_n++;
                        void'(exp_q.pop_front());
                    end
                end
            end
            prev_stall = rk_valid && !rk_ready;
            prev_data  = rk_data;
            if (key_valid && key_ready) begin
                push_expected(key_in);
                lat     = 0;
                waiting = 1'b1;
                got_n   = 0;
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_key_ready"}, {31'b0, key_ready}, 32'd1);
        check({tag, "_rk_valid"}, {31'b0, rk_valid}, 32'd0);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_rk_data"}, rk_data, 32'd0);
        check({tag, "_rk_round"}, {28'b0, rk_round}, 32'd0);
        check({tag, "_rk_last"}, {31'b0, rk_last}, 32'd0);
    endtask

    task automatic send_key(input logic [127:0] k);
        bit ok = 1'b0;
        key_in    = k;
        key_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (key_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("key_accept_timeout");
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_in    = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic run_stream(input bit rnd, input bit intrude, input logic [127:0] other);
        bit ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (intrude && c == 5) begin
                key_in    = other;
                key_valid = 1'b1;
            end
            if (intrude && c == 20) key_valid = 1'b0;
        end
        key_valid = 1'b0;
        if (!ok) fail_now("stream_timeout");
        rk_ready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        int vc;
        bit ok;
        rst       = 1'b1;
        key_valid = 1'b0;
        rk_ready  = 1'b0;
        key_in    = '0;

        build_sbox();
        check("model_sbox_00", {24'b0, sbox_m[8'h00]}, 32'h63);
        check("model_sbox_53", {24'b0, sbox_m[8'h53]}, 32'hed);
        expand(FIPS_KEY);
        check("model_w4", model_w[4], 32'ha0fafe17);
        check("model_w40", model_w[40], 32'hd014f9a8);
        check("model_w41", model_w[41], 32'hc9ee2589);
        check("model_w42", model_w[42], 32'he13f0cc8);
        check("model_w43", model_w[43], 32'hb6630ca6);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        @(posedge clk);
        #1;
        rst      = 1'b0;
        rk_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // FIPS-197 key, consumer always ready
        send_key(FIPS_KEY);
        vc = 0;
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (rk_valid) vc++;
            if (rk_valid && rk_last) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("fips_last_timeout");
        check("valid_cycles", vc, 44);
        @(posedge clk);
        #1;
        if (REV) begin
            check("rev_word0", got_data[0], 32'hd014f9a8);
            check("rev_word1", got_data[1], 32'hc9ee2589);
            check("rev_word2", got_data[2], 32'he13f0cc8);
            check("rev_word3", got_data[3], 32'hb6630ca6);
            check("rev_round0", {28'b0, got_round[0]}, 32'd10);
            check("rev_final", got_data[43], 32'h09cf4f3c);
            check("rev_final_round", {28'b0, got_round[43]}, 32'd0);
            check("rev_final_last", {31'b0, got_last[43]}, 32'd1);
        end else begin
            check("fwd_word0", got_data[0], 32'h2b7e1516);
            check("fwd_round0", {28'b0, got_round[0]}, 32'd0);
            check("fwd_word4", got_data[4], 32'ha0fafe17);
            check("fwd_round4", {28'b0, got_round[4]}, 32'd1);
            check("fwd_word43", got_data[43], 32'hb6630ca6);
            check("fwd_round43", {28'b0, got_round[43]}, 32'd10);
            check("fwd_last43", {31'b0, got_last[43]}, 32'd1);
        end

        // random backpressure with an ignored key offered mid-stream
        send_key(FIPS_KEY);
        run_stream(1'b1, 1'b1, 128'h000102030405060708090a0b0c0d0e0f);

        // reset at word 20, then restart with a fresh key
        rk_ready = 1'b1;
        send_key(128'h3c4fcf098815f7aba6d2ae2816157e2b);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            if (got_n >= 20) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("word20_timeout");
        check("words_before_reset", got_n, 20);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset("midreset");
        @(posedge clk);
        #1;
        send_key(128'hffeeddccbbaa99887766554433221100);
        run_stream(1'b0, 1'b0, '0);
        check("restart_first_word", got_data[0],
              REV ? model_w[40] : 32'hffeeddcc);

        // back-to-back keys with key_valid held high across the first stream
        send_key({$urandom(), $urandom(), $urandom(), $urandom()});
        send_key(128'h00000000000000000000000000000000);
        run_stream(1'b0, 1'b0, '0);
        check("b2b_final_last", {31'b0, got_last[43]}, 32'd1);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
